dynamic_predictor: RTL and testbench
====================================

# dynamic_predictor

Parametrised branch direction predictor for the RISC-V pipeline. It replaces the fixed sign-of-offset rule with a PC-indexed table of saturating counters and keeps that rule as a selectable static fallback. Predictions are produced combinationally in IF and carried through ID and EX alongside the instruction, honouring pipeline stall and flush. The counters are trained when each branch resolves in EX, and misprediction statistics are reported.

## Interface
- INDEX_BITS, 6: table index width; the table holds 2^INDEX_BITS entries, indexed by pc_if[INDEX_BITS+1:2].
- CNT_BITS, 2: saturating counter width, minimum 2.
- PC_WIDTH, 32: PC width.
- PERF_WIDTH, 16: performance counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- PL_stall_ex  in  1  freezes the ID and EX prediction stages.
- PL_flush_id  in  1  squashes the instruction entering or held in ID.
- mode_dynamic  in  1  1: use the counter table; 0: use static imme_sig.
- pc_if  in  PC_WIDTH  PC of the instruction in IF.
- branch_if  in  1  instruction in IF is a conditional branch.
- imme_sig  in  1  sign bit of the branch offset (static prediction).
- branch_taken_ex  in  1  resolved direction of the branch in EX.
- DP_prediction_result  out  1  IF-stage prediction, combinational.
- DP_prediction_result_id  out  1  prediction held in ID.
- DP_prediction_result_ex  out  1  prediction held in EX.
- DP_mispredict_ex  out  1  EX branch resolved opposite to its prediction.
- DP_branch_cnt  out  PERF_WIDTH  count of resolved branches.
- DP_mispredict_cnt  out  PERF_WIDTH  count of mispredictions.

## Operation
- Table entries are CNT_BITS wide. Reset value of every entry is weakly-not-taken, 2^(CNT_BITS-1)-1 (01 for 2 bits).
- Dynamic prediction is the counter MSB. DP_prediction_result = mode_dynamic ? MSB(table[idx_if]) : imme_sig.
- The prediction is driven regardless of branch_if. Only branch_if marks a stage valid.
- Per-stage state for ID and EX: valid, prediction, index.
- Stage advance happens when PL_stall_ex=0:
  - ID <= {branch_if, DP_prediction_result, idx_if};
  - EX <= ID.
- When PL_stall_ex=1, the ID and EX stages hold.
- PL_flush_id clears ID (valid=0, prediction=0):
  - flush without stall: ID loads the bubble and EX takes the old ID;
  - flush with stall: ID clears and EX holds.
  - Flush has priority over stall for ID only.
- Update event = valid_ex & !PL_stall_ex. It fires exactly once per resolved branch, even if the stall spans many cycles.
- On an update event, table[idx_ex] saturating-increments if branch_taken_ex=1, otherwise saturating-decrements. It saturates at 2^CNT_BITS-1 and 0.
- Training continues in static mode, so switching mode_dynamic needs no warm-up.
- DP_mispredict_ex = valid_ex & (pred_ex ^ branch_taken_ex), combinational. It compares against the prediction actually used at IF time, not the current table value.
- On each update event:
  - DP_branch_cnt increments;
  - DP_mispredict_cnt increments if DP_mispredict_ex=1.
  - Both counters saturate at all-ones and never wrap.
- Read/write collision: if idx_if == idx_ex during an update event, the IF read returns the post-update counter value (bypass).

## Timing
- Reset (asynchronous, any cycle): the table, ID/EX valid/prediction/index, and both perf counters go to reset values immediately. _id, _ex and DP_mispredict_ex read 0.
- IF prediction: zero latency, combinational from pc_if, imme_sig and mode_dynamic.
- IF to ID: 1 cycle. IF to EX: 2 cycles, plus stall cycles.
- Table and perf counter writes take effect at the clock edge ending the update cycle. They are visible to a different index on the next cycle and to the same index in the same cycle via bypass.
- The mode_dynamic change takes effect in the same cycle at IF. Predictions already in ID/EX are unaffected.
- Reset asserted mid-stall or mid-flush: reset wins and no update is performed.

## Test plan
- Reset, then mode_dynamic=1 with any PC -> DP_prediction_result=0 (counter 01); _id=_ex=0; both perf counters 0.
- Branch at PC 0x40 resolved taken twice -> table[16] goes 01→10→11; the third fetch of 0x40 predicts 1; DP_branch_cnt=2, DP_mispredict_cnt=1.
- Taken five times then not-taken -> counter saturates at 11 and then reads 10; the next prediction is still 1.
- mode_dynamic=0 with imme_sig=1 on an untrained PC -> prediction 1. A not-taken resolution asserts DP_mispredict_ex and decrements table[idx] to 00.
- PL_stall_ex held 3 cycles with a valid branch in EX -> _id/_ex are frozen; exactly one update and one DP_branch_cnt increment occur, on the first unstalled cycle.
- Collision: pc_if index equals idx_ex during an update (counter 01, taken) -> DP_prediction_result=1 in the same cycle. PL_flush_id in the same cycle -> the next _id reads 0 and no update follows for the squashed instruction.

Source files
------------

// File: rtl/dynamic_predictor.sv
// PC-indexed saturating-counter branch direction predictor with a static sign-of-offset
// fallback, per-stage prediction tracking through ID/EX, training at EX and miss statistics.
module dynamic_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int CNT_BITS   = 2,
    parameter int PC_WIDTH   = 32,
    parameter int PERF_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PL_stall_ex,
    input  logic                  PL_flush_id,
    input  logic                  mode_dynamic,
    input  logic [PC_WIDTH-1:0]   pc_if,
    input  logic                  branch_if,
    input  logic                  imme_sig,
    input  logic                  branch_taken_ex,
    output logic                  DP_prediction_result,
    output logic                  DP_prediction_result_id,
    output logic                  DP_prediction_result_ex,
    output logic                  DP_mispredict_ex,
    output logic [PERF_WIDTH-1:0] DP_branch_cnt,
    output logic [PERF_WIDTH-1:0] DP_mispredict_cnt
);

    localparam int                   ENTRIES   = 1 << INDEX_BITS;
    localparam logic [CNT_BITS-1:0]  CNT_INIT  = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0]  CNT_MAX   = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0]  CNT_ZERO  = {CNT_BITS{1'b0}};
    localparam logic [PERF_WIDTH-1:0] PERF_MAX = {PERF_WIDTH{1'b1}};

    logic [CNT_BITS-1:0]   table_q [ENTRIES];
    logic [INDEX_BITS-1:0] idx_if_s;
    logic                  valid_id_q, pred_id_q;
    logic [INDEX_BITS-1:0] idx_id_q;
    logic                  valid_ex_q, pred_ex_q;
    logic [INDEX_BITS-1:0] idx_ex_q;
    logic                  update_s;
    logic [CNT_BITS-1:0]   cnt_ex_s;
    logic [CNT_BITS-1:0]   cnt_d;
    logic [CNT_BITS-1:0]   cnt_rd_s;
    logic [PERF_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [PERF_WIDTH-1:0] mispredict_cnt_q, mispredict_cnt_d;
    logic                  unused_pc_s;

    assign idx_if_s    = pc_if[INDEX_BITS+1:2];
    assign unused_pc_s = ^{pc_if[PC_WIDTH-1:INDEX_BITS+2], pc_if[1:0]};
    assign update_s    = valid_ex_q & ~PL_stall_ex;
    assign cnt_ex_s    = table_q[idx_ex_q];

    // Saturating trained value of the EX entry and the bypassed IF read
    always_comb begin
        cnt_d    = cnt_ex_s;
        cnt_rd_s = table_q[idx_if_s];
        if (branch_taken_ex) begin
            if (cnt_ex_s != CNT_MAX) begin
                cnt_d = cnt_ex_s + CNT_BITS'(1);
            end else begin
                cnt_d = cnt_ex_s;
            end
        end else begin
            if (cnt_ex_s != CNT_ZERO) begin
                cnt_d = cnt_ex_s - CNT_BITS'(1);
            end else begin
                cnt_d = cnt_ex_s;
            end
        end
        if (update_s && (idx_if_s == idx_ex_q)) begin
            cnt_rd_s = cnt_d;
        end else begin
            cnt_rd_s = table_q[idx_if_s];
        end
    end

    // Saturating performance counter next values
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (update_s) begin
            if (branch_cnt_q != PERF_MAX) begin
                branch_cnt_d = branch_cnt_q + PERF_WIDTH'(1);
            end else begin
                branch_cnt_d = branch_cnt_q;
            end
            if (DP_mispredict_ex && (mispredict_cnt_q != PERF_MAX)) begin
                mispredict_cnt_d = mispredict_cnt_q + PERF_WIDTH'(1);
            end else begin
                mispredict_cnt_d = mispredict_cnt_q;
            end
        end else begin
            branch_cnt_d     = branch_cnt_q;
            mispredict_cnt_d = mispredict_cnt_q;
        end
    end

    assign DP_prediction_result    = mode_dynamic ? cnt_rd_s[CNT_BITS-1] : imme_sig;
    assign DP_prediction_result_id = pred_id_q;
    assign DP_prediction_result_ex = pred_ex_q;
    // Compared against the prediction used at fetch, not the current table contents
    assign DP_mispredict_ex        = valid_ex_q & (pred_ex_q ^ branch_taken_ex);
    assign DP_branch_cnt           = branch_cnt_q;
    assign DP_mispredict_cnt       = mispredict_cnt_q;

    // Counter table: trained once per resolved branch as it leaves EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CNT_INIT;
            end
        end else if (update_s) begin
            table_q[idx_ex_q] <= cnt_d;
        end
    end

    // ID/EX prediction pipeline; flush beats stall for ID only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_id_q <= 1'b0;
            pred_id_q  <= 1'b0;
            idx_id_q   <= {INDEX_BITS{1'b0}};
            valid_ex_q <= 1'b0;
            pred_ex_q  <= 1'b0;
            idx_ex_q   <= {INDEX_BITS{1'b0}};
        end else begin
            if (PL_flush_id) begin
                valid_id_q <= 1'b0;
                pred_id_q  <= 1'b0;
                idx_id_q   <= {INDEX_BITS{1'b0}};
            end else if (!PL_stall_ex) begin
                valid_id_q <= branch_if;
                pred_id_q  <= DP_prediction_result;
                idx_id_q   <= idx_if_s;
            end
            if (!PL_stall_ex) begin
                valid_ex_q <= valid_id_q;
                pred_ex_q  <= pred_id_q;
                idx_ex_q   <= idx_id_q;
            end
        end
    end

    // Branch and misprediction statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q     <= {PERF_WIDTH{1'b0}};
            mispredict_cnt_q <= {PERF_WIDTH{1'b0}};
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

endmodule

// File: tb/tb_dynamic_predictor.sv
// Directed bench for dynamic_predictor: training, saturation, static mode, stall, flush, bypass.
module tb_dynamic_predictor;

    logic        clk;
    logic        rst_n;
    logic        PL_stall_ex;
    logic        PL_flush_id;
    logic        mode_dynamic;
    logic [31:0] pc_if;
    logic        branch_if;
    logic        imme_sig;
    logic        branch_taken_ex;
    logic        DP_prediction_result;
    logic        DP_prediction_result_id;
    logic        DP_prediction_result_ex;
    logic        DP_mispredict_ex;
    logic [15:0] DP_branch_cnt;
    logic [15:0] DP_mispredict_cnt;

    int checks;
    int failures;

    dynamic_predictor dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .PL_stall_ex             (PL_stall_ex),
        .PL_flush_id             (PL_flush_id),
        .mode_dynamic            (mode_dynamic),
        .pc_if                   (pc_if),
        .branch_if               (branch_if),
        .imme_sig                (imme_sig),
        .branch_taken_ex         (branch_taken_ex),
        .DP_prediction_result    (DP_prediction_result),
        .DP_prediction_result_id (DP_prediction_result_id),
        .DP_prediction_result_ex (DP_prediction_result_ex),
        .DP_mispredict_ex        (DP_mispredict_ex),
        .DP_branch_cnt           (DP_branch_cnt),
        .DP_mispredict_cnt       (DP_mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch a branch, let it pass ID, resolve it in EX with no stall
    task automatic branch3(input logic [31:0] pc, input logic imm, input logic taken,
                           input logic exp_pred, input string tag);
        pc_if = pc; branch_if = 1'b1; imme_sig = imm;
        #1 check_eq({tag, "_if"}, 32'(DP_prediction_result), 32'(exp_pred));
        tick();
        branch_if = 1'b0; pc_if = 32'h0000_1000; imme_sig = 1'b0;
        #1 check_eq({tag, "_id"}, 32'(DP_prediction_result_id), 32'(exp_pred));
        tick();
        branch_taken_ex = taken;
        #1 check_eq({tag, "_ex"}, 32'(DP_prediction_result_ex), 32'(exp_pred));
        check_eq({tag, "_mis"}, 32'(DP_mispredict_ex), 32'(exp_pred ^ taken));
        tick();
        branch_taken_ex = 1'b0;
    endtask

    task automatic check_cnts(input string tag, input int exp_br, input int exp_mis);
        check_eq({tag, "_brcnt"}, 32'(DP_branch_cnt), 32'(exp_br));
        check_eq({tag, "_miscnt"}, 32'(DP_mispredict_cnt), 32'(exp_mis));
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; PL_stall_ex = 1'b0; PL_flush_id = 1'b0; mode_dynamic = 1'b1;
        pc_if = 32'h0000_0040; branch_if = 1'b0; imme_sig = 1'b0; branch_taken_ex = 1'b0;
        #3;
        check_eq("rst_pred", 32'(DP_prediction_result), 32'd0);
        check_eq("rst_id", 32'(DP_prediction_result_id), 32'd0);
        check_eq("rst_ex", 32'(DP_prediction_result_ex), 32'd0);
        check_eq("rst_mis", 32'(DP_mispredict_ex), 32'd0);
        check_cnts("rst", 0, 0);
        #9 rst_n = 1'b1;
        tick();

        // idx16 trained 01 -> 10 -> 11
        branch3(32'h0000_0040, 1'b0, 1'b1, 1'b0, "t40a");
        branch3(32'h0000_0040, 1'b0, 1'b1, 1'b1, "t40b");
        pc_if = 32'h0000_0040; branch_if = 1'b0;
        #1 check_eq("t40_third", 32'(DP_prediction_result), 32'd1);
        check_cnts("t40", 2, 1);

        // idx32: five taken saturate at 11, one not-taken leaves 10
        for (int i = 0; i < 5; i++) begin
            branch3(32'h0000_0080, 1'b0, 1'b1, (i == 0) ? 1'b0 : 1'b1, "sat");
        end
        branch3(32'h0000_0080, 1'b0, 1'b0, 1'b1, "satnt");
        pc_if = 32'h0000_0080;
        #1 check_eq("sat_after", 32'(DP_prediction_result), 32'd1);
        check_cnts("sat", 8, 3);

        // Mode switch is visible at IF in the same cycle
        mode_dynamic = 1'b0; pc_if = 32'h0000_0040; imme_sig = 1'b0;
        #1 check_eq("mode_static", 32'(DP_prediction_result), 32'd0);
        mode_dynamic = 1'b1;
        #1 check_eq("mode_dyn", 32'(DP_prediction_result), 32'd1);

        // Static prediction on idx48, training still happens (01 -> 00)
        mode_dynamic = 1'b0;
        branch3(32'h0000_00C0, 1'b1, 1'b0, 1'b1, "static");
        mode_dynamic = 1'b1;
        branch3(32'h0000_00C0, 1'b0, 1'b1, 1'b0, "postst");
        pc_if = 32'h0000_00C0;
        #1 check_eq("static_dec", 32'(DP_prediction_result), 32'd0);
        check_cnts("static", 10, 5);

        // Stall: EX holds idx16 (11) not-taken, ID holds idx0 branch
        pc_if = 32'h0000_0040; branch_if = 1'b1;
        #1 check_eq("stl_f0", 32'(DP_prediction_result), 32'd1);
        tick();
        pc_if = 32'h0000_1000; branch_if = 1'b1;
        #1 check_eq("stl_f1", 32'(DP_prediction_result), 32'd0);
        tick();
        PL_stall_ex = 1'b1; branch_if = 1'b0; pc_if = 32'h0000_0204; branch_taken_ex = 1'b0;
        #1 check_eq("stl_mis", 32'(DP_mispredict_ex), 32'd1);
        check_eq("stl_ex0", 32'(DP_prediction_result_ex), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("stl_ex", 32'(DP_prediction_result_ex), 32'd1);
            check_eq("stl_id", 32'(DP_prediction_result_id), 32'd0);
            check_cnts("stl_hold", 10, 5);
        end
        tick();
        PL_stall_ex = 1'b0;
        #1 check_cnts("stl_last", 10, 5);
        tick();
        check_cnts("stl_upd", 11, 6);
        check_eq("stl_ex2", 32'(DP_prediction_result_ex), 32'd0);
        check_eq("stl_mis2", 32'(DP_mispredict_ex), 32'd0);
        tick();
        check_cnts("stl_upd2", 12, 6);
        pc_if = 32'h0000_0040;
        #1 check_eq("stl_once", 32'(DP_prediction_result), 32'd1);

        // Collision bypass on idx2 with flush of the fetched copy
        pc_if = 32'h0000_0008; branch_if = 1'b1;
        #1 check_eq("col_f", 32'(DP_prediction_result), 32'd0);
        tick();
        pc_if = 32'h0000_1000; branch_if = 1'b0;
        tick();
        pc_if = 32'h0000_0008; branch_if = 1'b1; PL_flush_id = 1'b1; branch_taken_ex = 1'b1;
        #1 check_eq("col_bypass", 32'(DP_prediction_result), 32'd1);
        check_eq("col_mis", 32'(DP_mispredict_ex), 32'd1);
        tick();
        PL_flush_id = 1'b0; branch_if = 1'b0; pc_if = 32'h0000_1000;
        #1 check_eq("flush_id", 32'(DP_prediction_result_id), 32'd0);
        check_cnts("col", 13, 7);
        tick();
        check_eq("flush_ex_mis", 32'(DP_mispredict_ex), 32'd0);
        tick();
        check_cnts("flush_noupd", 13, 7);
        pc_if = 32'h0000_0008; branch_if = 1'b1; branch_taken_ex = 1'b0;
        #1 check_eq("col_after", 32'(DP_prediction_result), 32'd1);
        tick();
        check_eq("pre_rst_id", 32'(DP_prediction_result_id), 32'd1);

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1 check_eq("arst_id", 32'(DP_prediction_result_id), 32'd0);
        check_eq("arst_pred", 32'(DP_prediction_result), 32'd0);
        check_cnts("arst", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
